mem_access_scheduler: RTL and testbench

MEM_ACCESS_SCHEDULER -- requirements
Module: mem_access_scheduler

---
 rtl/mem_sched_pkg.sv | 32 +++
 rtl/rr_pick4.sv | 27 ++
 rtl/mem_access_scheduler.sv | 134 +++++++++++++
 tb/tb_mem_access_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared constants, FSM encodings and helpers
// for the four-core memory access scheduler.
package mem_sched_pkg;

    localparam int NCORE = 4;

    localparam logic [3:0] NOC_MIN = 4'd1;
    localparam logic [3:0] NOC_MAX = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    // Clamp noc to 1..4 and return the mask of cores allowed to arbitrate.
    function automatic logic [3:0] elig_mask(input logic [3:0] noc);
        logic [3:0] eff;
        logic [3:0] m;
        if (noc < NOC_MIN)
            eff = NOC_MIN;
        else if (noc > NOC_MAX)
            eff = NOC_MAX;
        else
            eff = noc;
        m = '0;
        for (int i = 0; i < NCORE; i++)
            m[i] = (4'(i) < eff);
        return m;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: first requester
// strictly after last, wrapping; last itself is lowest priority.
module rr_pick4
    import mem_sched_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       valid
);

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [1:0] idx;
        grant = last;
        valid = 1'b0;
        idx   = last;
        for (int k = NCORE; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_scheduler.sv
// Round-robin scheduler sharing one single-port memory
// among up to four cores; all outputs registered.
module mem_access_scheduler
    import mem_sched_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          noc,
    input  logic [3:0]          core_req,
    input  logic [3:0]          core_we,
    input  logic [4*ADDR_W-1:0] core_addr,
    input  logic [4*DATA_W-1:0] core_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [3:0]          core_ack,
    output logic [DATA_W-1:0]   rd_data,
    output logic                busy
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t             state, state_n;
    logic [2:0]         cnt, cnt_n;
    logic [1:0]         gnt, gnt_n;
    logic [1:0]         last_grant, last_n;
    logic               en_n, we_n, busy_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [DATA_W-1:0]  wd_n, rd_n;
    logic [3:0]         ack_n;
    logic [3:0]         elig;
    logic [1:0]         pick;
    logic               pick_ok;

    // The core just acknowledged is masked so a held req is not re-granted.
    always_comb begin
        elig = core_req & elig_mask(noc) & ~core_ack;
    end

    rr_pick4 u_pick (
        .req   (elig),
        .last  (last_grant),
        .grant (pick),
        .valid (pick_ok)
    );

    // Next-state and next-output logic; registers hold unless updated.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_n   = gnt;
        last_n  = last_grant;
        en_n    = 1'b0;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wd_n    = mem_wdata;
        ack_n   = 4'b0000;
        rd_n    = rd_data;
        unique case (state)
            S_IDLE: begin
                if (pick_ok) begin
                    state_n = S_ACCESS;
                    gnt_n   = pick;
                    last_n  = pick;
                    en_n    = 1'b1;
                    we_n    = core_we[pick];
                    addr_n  = core_addr[pick*ADDR_W +: ADDR_W];
                    wd_n    = core_wdata[pick*DATA_W +: DATA_W];
                end
            end
            S_ACCESS: begin
                if (LAT == 3'd1) begin
                    state_n = S_IDLE;
                    ack_n   = 4'b0001 << gnt;
                    if (!mem_we)
                        rd_n = mem_rdata;
                end else begin
                    state_n = S_WAIT;
                    cnt_n   = 3'd2;
                end
            end
            S_WAIT: begin
                if (cnt == LAT) begin
                    state_n = S_IDLE;
                    ack_n   = 4'b0001 << gnt;
                    if (!mem_we)
                        rd_n = mem_rdata;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // State and output registers; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            gnt        <= 2'd0;
            last_grant <= 2'd3;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_ack   <= 4'b0000;
            rd_data    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            gnt        <= gnt_n;
            last_grant <= last_n;
            mem_en     <= en_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wd_n;
            core_ack   <= ack_n;
            rd_data    <= rd_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Directed bench: table of single transactions on a MEM_LAT=1
// instance plus sequences for round-robin, masking and reset.
module tb_mem_access_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  noc = 4'd4;
    logic [3:0]  core_req = 4'b0;
    logic [3:0]  core_we = 4'b0;
    logic [63:0] core_addr;
    logic [31:0] core_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    logic        en1, we1, busy1;
    logic [15:0] addr1;
    logic [7:0]  wd1, rd1;
    logic [3:0]  ack1;
    logic        en3, we3, busy3;
    logic [15:0] addr3;
    logic [7:0]  wd3, rd3;
    logic [3:0]  ack3;

    logic [15:0] exp_addr [4];
    logic [7:0]  exp_wd [4];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access_scheduler #(.DATA_W(8), .ADDR_W(16), .MEM_LAT(1)) d1 (
        .clk(clk), .rst(rst), .noc(noc), .core_req(core_req),
        .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .mem_rdata(mem_rdata),
        .mem_en(en1), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wd1), .core_ack(ack1), .rd_data(rd1),
        .busy(busy1)
    );

    mem_access_scheduler #(.DATA_W(8), .ADDR_W(16), .MEM_LAT(3)) d3 (
        .clk(clk), .rst(rst), .noc(noc), .core_req(core_req),
        .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .mem_rdata(mem_rdata),
        .mem_en(en3), .mem_we(we3), .mem_addr(addr3),
        .mem_wdata(wd3), .core_ack(ack3), .rd_data(rd3),
        .busy(busy3)
    );

    typedef struct {
        logic [3:0] noc;
        logic [3:0] req;
        logic [3:0] we;
        logic [7:0] rdata;
        logic       hit;
        logic [1:0] core;
        logic [7:0] rd;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        core_req = 4'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero3(input string tag);
        chk({tag, "_en"}, 32'(en3), 0);
        chk({tag, "_we"}, 32'(we3), 0);
        chk({tag, "_addr"}, 32'(addr3), 0);
        chk({tag, "_wd"}, 32'(wd3), 0);
        chk({tag, "_ack"}, 32'(ack3), 0);
        chk({tag, "_rd"}, 32'(rd3), 0);
        chk({tag, "_busy"}, 32'(busy3), 0);
    endtask

    initial begin
        exp_addr[0] = 16'h0010; exp_addr[1] = 16'h0100;
        exp_addr[2] = 16'h0200; exp_addr[3] = 16'h0300;
        exp_wd[0] = 8'h11; exp_wd[1] = 8'hA5;
        exp_wd[2] = 8'h22; exp_wd[3] = 8'h33;
        core_addr  = {16'h0300, 16'h0200, 16'h0100, 16'h0010};
        core_wdata = {8'h33, 8'h22, 8'hA5, 8'h11};

        vt[0] = '{4'd4, 4'b0001, 4'b0000, 8'h3C, 1'b1, 2'd0, 8'h3C};
        vt[1] = '{4'd4, 4'b0010, 4'b0010, 8'hFF, 1'b1, 2'd1, 8'h3C};
        vt[2] = '{4'd2, 4'b1100, 4'b0000, 8'hFF, 1'b0, 2'd0, 8'h3C};
        vt[3] = '{4'd0, 4'b0011, 4'b0000, 8'h77, 1'b1, 2'd0, 8'h77};
        vt[4] = '{4'd0, 4'b0010, 4'b0000, 8'h99, 1'b0, 2'd0, 8'h77};
        vt[5] = '{4'd9, 4'b1000, 4'b0000, 8'h5E, 1'b1, 2'd3, 8'h5E};
        vt[6] = '{4'd4, 4'b1010, 4'b0000, 8'h81, 1'b1, 2'd1, 8'h81};
        vt[7] = '{4'd3, 4'b1101, 4'b0000, 8'h42, 1'b1, 2'd2, 8'h42};
        vt[8] = '{4'd4, 4'b1101, 4'b1111, 8'hC3, 1'b1, 2'd3, 8'h42};

        // reset state
        tick();
        tick();
        chk("rst1_en", 32'(en1), 0);
        chk("rst1_ack", 32'(ack1), 0);
        chk("rst1_busy", 32'(busy1), 0);
        chk("rst1_addr", 32'(addr1), 0);
        chk("rst1_rd", 32'(rd1), 0);
        chk_zero3("rst3");
        @(negedge clk);
        rst = 1'b0;

        // single-transaction table on MEM_LAT=1
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            noc = vt[i].noc;
            core_req = vt[i].req;
            core_we = vt[i].we;
            mem_rdata = vt[i].rdata;
            tick();
            if (vt[i].hit) begin
                chk($sformatf("v%0d_en", i), 32'(en1), 1);
                chk($sformatf("v%0d_addr", i), 32'(addr1),
                    32'(exp_addr[vt[i].core]));
                chk($sformatf("v%0d_wd", i), 32'(wd1),
                    32'(exp_wd[vt[i].core]));
                chk($sformatf("v%0d_we", i), 32'(we1),
                    32'(vt[i].we[vt[i].core]));
                chk($sformatf("v%0d_busy", i), 32'(busy1), 1);
            end else begin
                chk($sformatf("v%0d_noen", i), 32'(en1), 0);
                chk($sformatf("v%0d_nobusy", i), 32'(busy1), 0);
            end
            tick();
            chk($sformatf("v%0d_ack", i), 32'(ack1),
                vt[i].hit ? 32'(4'b0001 << vt[i].core) : 0);
            chk($sformatf("v%0d_rd", i), 32'(rd1), 32'(vt[i].rd));
            chk($sformatf("v%0d_en2", i), 32'(en1), 0);
            chk($sformatf("v%0d_idle", i), 32'(busy1), 0);
            @(negedge clk);
            core_req = 4'b0;
            core_we = 4'b0;
        end

        // all four request, each drops after its ack
        rst_pulse();
        @(negedge clk);
        noc = 4'd4;
        core_req = 4'b1111;
        mem_rdata = 8'h10;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("rr%0d_ack", i), 32'(ack1),
                (i % 2 == 0) ? 32'(4'b0001 << (i / 2 - 1)) : 0);
            chk($sformatf("rr%0d_en", i), 32'(en1), 32'(i % 2));
            if (i % 2 == 1)
                chk($sformatf("rr%0d_addr", i), 32'(addr1),
                    32'(exp_addr[(i - 1) / 2]));
            else begin
                @(negedge clk);
                core_req[i / 2 - 1] = 1'b0;
            end
        end

        // held req masked during its own ack cycle
        rst_pulse();
        @(negedge clk);
        core_req = 4'b1100;
        tick();
        chk("m_g2_en", 32'(en1), 1);
        chk("m_g2_addr", 32'(addr1), 32'(16'h0200));
        tick();
        chk("m_ack2", 32'(ack1), 32'(4'b0100));
        tick();
        chk("m_g3_en", 32'(en1), 1);
        chk("m_g3_addr", 32'(addr1), 32'(16'h0300));
        tick();
        chk("m_ack3", 32'(ack1), 32'(4'b1000));
        @(negedge clk);
        core_req = 4'b1000;
        tick();
        chk("m_nodouble", 32'(en1), 0);
        tick();
        chk("m_regrant", 32'(en1), 1);
        chk("m_regrant_addr", 32'(addr1), 32'(16'h0300));
        @(negedge clk);
        core_req = 4'b0;

        // MEM_LAT=3 latency, then reset in WAIT
        rst_pulse();
        @(negedge clk);
        core_req = 4'b0010;
        mem_rdata = 8'h9A;
        tick();
        chk("l3_en", 32'(en3), 1);
        chk("l3_addr", 32'(addr3), 32'(16'h0100));
        tick();
        chk("l3_en_off", 32'(en3), 0);
        chk("l3_busy", 32'(busy3), 1);
        chk("l3_noack1", 32'(ack3), 0);
        tick();
        chk("l3_noack2", 32'(ack3), 0);
        tick();
        chk("l3_ack", 32'(ack3), 32'(4'b0010));
        chk("l3_rd", 32'(rd3), 32'(8'h9A));
        chk("l3_idle", 32'(busy3), 0);
        @(negedge clk);
        core_req = 4'b0100;
        tick();
        chk("r_g2_en", 32'(en3), 1);
        chk("r_g2_addr", 32'(addr3), 32'(16'h0200));
        tick();
        chk("r_wait", 32'(busy3), 1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_zero3("r_abort");
        @(negedge clk);
        rst = 1'b0;
        core_req = 4'b1111;
        tick();
        chk("r_noack", 32'(ack3), 0);
        chk("r_next_en", 32'(en3), 1);
        chk("r_next_core0", 32'(addr3), 32'(16'h0010));
        rst_pulse();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
